// File: rtl/fpu_round_pkg.sv
// Rounding-mode encodings shared by the FPU rounding and alignment logic.
package fpu_round_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } round_mode_t;

endpackage

// File: rtl/sticky_or_reduce.sv
// OR reduction of a bit field. Used here for the sticky bit and also by the
// adder alignment shifter.
module sticky_or_reduce #(
  parameter int W = 22
) (
  input  logic [W-1:0] i_bits,
  output logic         o_any
);

  assign o_any = |i_bits;

endmodule

// File: rtl/sgf_round_pipe.sv
// Two-stage significand rounding pipeline. Stage 1 captures the kept bits and
// the guard/sticky bits; stage 2 applies the rounding mode and registers the result.
module sgf_round_pipe
  import fpu_round_pkg::*;
#(
  parameter int W_KEEP = 24,
  parameter int W_DISC = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_KEEP+W_DISC-1:0] Sgf_In,
  input  logic                     Sign_In,
  input  logic [1:0]               Round_Mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W_KEEP-1:0]        Sgf_Out,
  output logic                     Exp_Inc,
  output logic                     Inexact
);

  function automatic logic round_inc(input round_mode_t mode, input logic lsb,
                                     input logic guard, input logic sticky,
                                     input logic sign);
    logic inc;
    unique case (mode)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      default: inc = (guard | sticky) & sign;
    endcase
    return inc;
  endfunction

  logic [W_KEEP-1:0] r_kept_p1;
  logic              r_guard_p1;
  logic              r_sticky_p1;
  logic              r_sign_p1;
  round_mode_t       r_mode_p1;
  logic              r_vld_p1;
  logic              r_vld_p2;
  logic [W_KEEP-1:0] r_sgf_p2;
  logic              r_exp_inc_p2;
  logic              r_inexact_p2;

  logic              w_sticky;
  logic              w_s2_adv;
  logic              w_in_ready;
  logic              w_inc;
  logic [W_KEEP:0]   w_sum;
  logic [W_KEEP-1:0] w_sgf;

  sticky_or_reduce #(.W(W_DISC-1)) u_sticky (
    .i_bits (Sgf_In[W_DISC-2:0]),
    .o_any  (w_sticky)
  );

  // No skid buffer: stage 1 may only take a beat if it is empty or draining.
  assign w_s2_adv   = ~r_vld_p2 | out_ready;
  assign w_in_ready = ~r_vld_p1 | w_s2_adv;
  assign in_ready   = w_in_ready;

  // ---- stage 1: split kept / guard / sticky ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_in_ready) begin
      r_kept_p1   <= Sgf_In[W_KEEP+W_DISC-1:W_DISC];
      r_guard_p1  <= Sgf_In[W_DISC-1];
      r_sticky_p1 <= w_sticky;
      r_sign_p1   <= Sign_In;
      r_mode_p1   <= round_mode_t'(Round_Mode);
    end
  end

  // ---- stage 2: increment, renormalise on carry-out ----
  assign w_inc = round_inc(r_mode_p1, r_kept_p1[0], r_guard_p1, r_sticky_p1, r_sign_p1);
  assign w_sum = {1'b0, r_kept_p1} + {{W_KEEP{1'b0}}, w_inc};
  assign w_sgf = w_sum[W_KEEP] ? w_sum[W_KEEP:1] : w_sum[W_KEEP-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p2     <= 1'b0;
      r_sgf_p2     <= '0;
      r_exp_inc_p2 <= 1'b0;
      r_inexact_p2 <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sgf_p2     <= w_sgf;
        r_exp_inc_p2 <= w_sum[W_KEEP];
        r_inexact_p2 <= r_guard_p1 | r_sticky_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign Sgf_Out   = r_sgf_p2;
  assign Exp_Inc   = r_exp_inc_p2;
  assign Inexact   = r_inexact_p2;

endmodule

// File: tb/tb_sgf_round_pipe.sv
// Testbench for sgf_round_pipe: directed rounding cases plus randomized
// backpressure streaming checked against an arithmetic reference model.
module tb_sgf_round_pipe;

  localparam int WK = 24;
  localparam int WD = 23;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WK+WD-1:0] Sgf_In = '0;
  logic             Sign_In = 1'b0;
  logic [1:0]       Round_Mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WK-1:0]    Sgf_Out;
  logic             Exp_Inc;
  logic             Inexact;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WK-1:0] so;
    logic          ei;
    logic          ix;
  } exp_t;

  sgf_round_pipe #(.W_KEEP(WK), .W_DISC(WD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Sgf_In     (Sgf_In),
    .Sign_In    (Sign_In),
    .Round_Mode (Round_Mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Sgf_Out    (Sgf_Out),
    .Exp_Inc    (Exp_Inc),
    .Inexact    (Inexact)
  );

  always #5 clk = ~clk;

  // Reference: compare the discarded value against one half ULP numerically.
  function automatic exp_t ref_round(input logic [WK-1:0] k, input logic [WD-1:0] d,
                                     input logic sg, input logic [1:0] m);
    exp_t r;
    longint unsigned half, dv, sum;
    bit up;
    half = longint'(1) << (WD - 1);
    dv   = longint'(d);
    r.ix = (d != 0);
    case (m)
      2'd0:    up = (dv > half) || (dv == half && k[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = r.ix && !sg;
      default: up = r.ix && sg;
    endcase
    sum = longint'(k) + longint'(up);
    if (sum >= (longint'(1) << WK)) begin
      r.so = WK'(sum >> 1);
      r.ei = 1'b1;
    end else begin
      r.so = WK'(sum);
      r.ei = 1'b0;
    end
    return r;
  endfunction

  // Sends one beat into an idle pipe and waits (bounded) for its result.
  task automatic run_beat(input logic [WK-1:0] k, input logic [WD-1:0] d,
                          input logic sg, input logic [1:0] m,
                          output exp_t got, output int lat);
    @(posedge clk); #1;
    Sgf_In     = {k, d};
    Sign_In    = sg;
    Round_Mode = m;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    lat        = -1;
    got.so = 'x; got.ei = 1'bx; got.ix = 1'bx;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (out_valid) begin
        lat = c;
        got.so = Sgf_Out; got.ei = Exp_Inc; got.ix = Inexact;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || Sgf_Out !== '0 || Exp_Inc !== 1'b0 || Inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b sgf=%h ei=%b ix=%b, want all 0",
               out_valid, Sgf_Out, Exp_Inc, Inexact);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Sgf_In = {WK'($urandom), WD'($urandom)};
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_stream_flowing: got out_valid=%b want 1", out_valid);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Sgf_Out !== '0) begin
      errors++;
      $display("FAIL reset_async: got vld=%b sgf=%h want 0/0", out_valid, Sgf_Out);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_output: got out_valid=1 after release want 0");
    end
  endtask

  task automatic test_rne_tie();
    exp_t g;
    int   lat;
    run_beat(24'h800001, 23'h400000, 1'b0, 2'b00, g, lat);
    checks++;
    if (g.so !== 24'h800002 || g.ix !== 1'b1 || g.ei !== 1'b0) begin
      errors++;
      $display("FAIL rne_tie_odd: got sgf=%h ix=%b ei=%b want 800002/1/0", g.so, g.ix, g.ei);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL latency: got %0d want 2", lat);
    end
    run_beat(24'h800002, 23'h400000, 1'b0, 2'b00, g, lat);
    checks++;
    if (g.so !== 24'h800002 || g.ix !== 1'b1 || g.ei !== 1'b0) begin
      errors++;
      $display("FAIL rne_tie_even: got sgf=%h ix=%b ei=%b want 800002/1/0", g.so, g.ix, g.ei);
    end
  endtask

  task automatic test_directed();
    exp_t          g;
    int            lat;
    logic [WK-1:0] want [3] = '{24'h8000FF, 24'h800100, 24'h8000FF};
    for (int i = 0; i < 3; i++) begin
      run_beat(24'h8000FF, 23'h000001, 1'b0, 2'(i + 1), g, lat);
      checks++;
      if (g.so !== want[i] || g.ix !== 1'b1 || g.ei !== 1'b0) begin
        errors++;
        $display("FAIL directed_mode%0d: got sgf=%h ix=%b ei=%b want %h/1/0",
                 i + 1, g.so, g.ix, g.ei, want[i]);
      end
    end
    run_beat(24'h8000FF, 23'h000001, 1'b1, 2'b11, g, lat);
    checks++;
    if (g.so !== 24'h800100 || g.ix !== 1'b1) begin
      errors++;
      $display("FAIL directed_rdn_neg: got sgf=%h ix=%b want 800100/1", g.so, g.ix);
    end
  endtask

  task automatic test_overflow();
    exp_t g;
    int   lat;
    run_beat(24'hFFFFFF, 23'h7FFFFF, 1'b0, 2'b10, g, lat);
    checks++;
    if (g.so !== 24'h800000 || g.ei !== 1'b1 || g.ix !== 1'b1) begin
      errors++;
      $display("FAIL overflow_rup: got sgf=%h ei=%b ix=%b want 800000/1/1", g.so, g.ei, g.ix);
    end
    run_beat(24'hFFFFFF, 23'h400000, 1'b1, 2'b00, g, lat);
    checks++;
    if (g.so !== 24'h800000 || g.ei !== 1'b1) begin
      errors++;
      $display("FAIL overflow_rne: got sgf=%h ei=%b want 800000/1", g.so, g.ei);
    end
  endtask

  task automatic test_exact();
    exp_t          g;
    int            lat;
    logic [WK-1:0] k;
    for (int m = 0; m < 4; m++) begin
      k = WK'($urandom) | 24'h800000;
      if (m == 3) k = 24'hFFFFFF;
      run_beat(k, '0, 1'($urandom), 2'(m), g, lat);
      checks++;
      if (g.so !== k || g.ix !== 1'b0 || g.ei !== 1'b0) begin
        errors++;
        $display("FAIL exact_mode%0d: got sgf=%h ix=%b ei=%b want %h/0/0", m, g.so, g.ix, g.ei, k);
      end
    end
  endtask

  task automatic test_random();
    exp_t          g, e;
    int            lat;
    logic [WK-1:0] k;
    logic [WD-1:0] d;
    logic          sg;
    logic [1:0]    m;
    for (int i = 0; i < 8; i++) begin
      k  = WK'($urandom);
      d  = (i % 3 == 0) ? 23'h400000 : WD'($urandom);
      sg = 1'($urandom);
      m  = 2'($urandom);
      e  = ref_round(k, d, sg, m);
      run_beat(k, d, sg, m, g, lat);
      checks++;
      if (g.so !== e.so || g.ei !== e.ei || g.ix !== e.ix || lat !== 2) begin
        errors++;
        $display("FAIL random_%0d: got sgf=%h ei=%b ix=%b lat=%0d want %h/%b/%b lat=2",
                 i, g.so, g.ei, g.ix, lat, e.so, e.ei, e.ix);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t held, e;
    int   sent, got;
    bit   stalled, in_fire;
    logic [WK-1:0] k;
    logic [WD-1:0] d;
    sent = 0; got = 0; stalled = 1'b0;
    @(posedge clk); #1;
    k = WK'($urandom); d = WD'($urandom);
    Sgf_In = {k, d}; Sign_In = 1'($urandom); Round_Mode = 2'($urandom);
    in_valid = 1'b1;
    out_ready = 1'($urandom);
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || Sgf_Out !== held.so || Exp_Inc !== held.ei || Inexact !== held.ix) begin
          errors++;
          $display("FAIL bp_stable: got vld=%b sgf=%h ei=%b ix=%b want 1/%h/%b/%b",
                   out_valid, Sgf_Out, Exp_Inc, Inexact, held.so, held.ei, held.ix);
        end
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held.so = Sgf_Out; held.ei = Exp_Inc; held.ix = Inexact;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_beat: got sgf=%h want no beat", Sgf_Out);
        end else begin
          e = q.pop_front();
          if (Sgf_Out !== e.so || Exp_Inc !== e.ei || Inexact !== e.ix) begin
            errors++;
            $display("FAIL bp_beat%0d: got sgf=%h ei=%b ix=%b want %h/%b/%b",
                     got, Sgf_Out, Exp_Inc, Inexact, e.so, e.ei, e.ix);
          end
        end
        got++;
      end
      in_fire = in_valid && in_ready;
      if (in_fire) begin
        q.push_back(ref_round(Sgf_In[WK+WD-1:WD], Sgf_In[WD-1:0], Sign_In, Round_Mode));
        sent++;
      end
      @(posedge clk); #1;
      if (in_fire) begin
        if (sent < 8) begin
          k = WK'($urandom);
          d = ($urandom % 4 == 0) ? 23'h400000 : WD'($urandom);
          Sgf_In = {k, d}; Sign_In = 1'($urandom); Round_Mode = 2'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom);
    end
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d beats (%0d pending) want 8 (0 pending)", got, q.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL bp_no_duplicate: got %0d extra beats want 0", got);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rne_tie();
    test_directed();
    test_overflow();
    test_exact();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
